// File: rtl/count_ctrl_fsm.sv
// rtl/count_ctrl_fsm.sv - control FSM sequencing load, scan and count of the 8-bit count datapath
module count_ctrl_fsm #(
    parameter int N_STEPS = 8,
    parameter int IDX_W   = $clog2(N_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             Aeq10,
    output logic             Load_En,
    output logic             shift_En,
    output logic             count_Load,
    output logic             count_Clr,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] scan_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    idx   <= '0;
                    state <= abort ? IDLE : SCAN;
                end
                SCAN: begin
                    // abort wins over the last-step transition, so no done pulse follows it
                    if (abort) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (idx == LAST_IDX) begin
                        state <= DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Outputs decode the registered state so async reset clears them immediately;
    // count_Load follows the comparator flag within the same SCAN cycle.
    always_comb begin
        Load_En    = 1'b0;
        shift_En   = 1'b0;
        count_Load = 1'b0;
        count_Clr  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        scan_idx   = '0;
        case (state)
            LOAD: begin
                Load_En   = 1'b1;
                count_Clr = 1'b1;
                busy      = 1'b1;
            end
            SCAN: begin
                busy       = 1'b1;
                count_Load = Aeq10;
                scan_idx   = idx;
                shift_En   = (idx != LAST_IDX);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_count_ctrl_fsm.sv
// tb/tb_count_ctrl_fsm.sv - randomized self-checking bench for count_ctrl_fsm
module tb_count_ctrl_fsm;

    localparam int N  = 8;
    localparam int IW = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          Aeq10;
    logic          Load_En;
    logic          shift_En;
    logic          count_Load;
    logic          count_Clr;
    logic          busy;
    logic          done;
    logic [IW-1:0] scan_idx;

    int errors = 0;
    int checks = 0;

    count_ctrl_fsm #(.N_STEPS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .Aeq10      (Aeq10),
        .Load_En    (Load_En),
        .shift_En   (shift_En),
        .count_Load (count_Load),
        .count_Clr  (count_Clr),
        .busy       (busy),
        .done       (done),
        .scan_idx   (scan_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {Load_En, shift_En, count_Load, count_Clr, busy, done};
    endfunction

    // Datapath count register emulated from the enables, checked against pattern arithmetic.
    int count_reg = 0;

    // One run starting from IDLE; abort_at < 0 means no abort. Ends with the DUT in IDLE
    // (or still holding start=1 in IDLE when hold is set).
    task automatic run_scan(input logic [7:0] pat, input int abort_at, input bit hold, input string tag);
        int         sh_n;
        int         cl_n;
        int         cnt_exp;
        int         sh_exp;
        int         last;
        bit         aborted;
        logic [5:0] exp_o;
        sh_n    = 0;
        cl_n    = 0;
        aborted = 0;
        start   = 1'b1;
        abort   = 1'b0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        Aeq10 = 1'($urandom);
        @(negedge clk);
        checks++;
        if (outs() !== 6'b100110 || scan_idx !== '0) begin
            errors++;
            $display("FAIL %s load_cycle: got outs=%b idx=%0d want outs=100110 idx=0", tag, outs(), scan_idx);
        end
        if (count_Clr) count_reg = 0;
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #1;
            Aeq10 = pat[k];
            abort = (k == abort_at);
            @(negedge clk);
            exp_o = {1'b0, (k < N - 1), pat[k], 1'b0, 1'b1, 1'b0};
            checks++;
            if (outs() !== exp_o || scan_idx !== IW'(k)) begin
                errors++;
                $display("FAIL %s scan_k%0d: got outs=%b idx=%0d want outs=%b idx=%0d", tag, k, outs(), scan_idx, exp_o, k);
            end
            if (shift_En) sh_n++;
            if (count_Load) begin
                cl_n++;
                count_reg++;
            end
            if (k == abort_at) begin
                aborted = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        abort = 1'($urandom);
        Aeq10 = 1'($urandom);
        @(negedge clk);
        exp_o = aborted ? 6'b000000 : 6'b000001;
        checks++;
        if (outs() !== exp_o || scan_idx !== '0) begin
            errors++;
            $display("FAIL %s end_cycle: got outs=%b idx=%0d want outs=%b idx=0", tag, outs(), scan_idx, exp_o);
        end
        abort   = 1'b0;
        last    = aborted ? abort_at : N - 1;
        cnt_exp = 0;
        for (int k = 0; k <= last; k++) cnt_exp += int'(pat[k]);
        sh_exp = (last < N - 1) ? last + 1 : N - 1;
        checks++;
        if (count_reg !== cnt_exp || cl_n !== cnt_exp || sh_n !== sh_exp) begin
            errors++;
            $display("FAIL %s totals: got count=%0d incs=%0d shifts=%0d want count=%0d incs=%0d shifts=%0d",
                     tag, count_reg, cl_n, sh_n, cnt_exp, cnt_exp, sh_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        Aeq10 = 1'b1;
        #2;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (outs() !== 6'b0 || scan_idx !== '0) begin
                errors++;
                $display("FAIL reset_held: got outs=%b idx=%0d want 0", outs(), scan_idx);
            end
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (outs() !== 6'b0 || scan_idx !== '0) begin
                errors++;
                $display("FAIL reset_idle: got outs=%b idx=%0d want 0", outs(), scan_idx);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_patterns();
        run_scan(8'b0101_0101, -1, 0, "alt");
        run_scan(8'hFF, -1, 0, "all_one");
        run_scan(8'h00, -1, 0, "all_zero");
        run_scan(8'hFF, -1, 0, "rerun_clears");
        for (int r = 0; r < 6; r++) run_scan(8'($urandom), -1, 0, "rand");
    endtask

    task automatic test_abort();
        run_scan(8'hFF, 3, 0, "abort_idx3");
        run_scan(8'($urandom), N - 1, 0, "abort_last");
        run_scan(8'($urandom), 0, 0, "abort_first");
        for (int r = 0; r < 6; r++) begin
            int a;
            a = int'($urandom_range(0, 10)) - 1;
            run_scan(8'($urandom), (a >= N) ? -1 : a, 0, "rand_abort");
        end
    endtask

    task automatic test_start_held();
        run_scan(8'($urandom), -1, 1, "held");
        @(negedge clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL held_idle_gap: got outs=%b want 000000", outs());
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 6'b100110) begin
            errors++;
            $display("FAIL held_reload: got outs=%b want 100110", outs());
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 6'b0) begin
            errors++;
            $display("FAIL abort_in_load: got outs=%b want 000000", outs());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            #1;
            Aeq10 = 1'b1;
        end
        #1;
        checks++;
        if (scan_idx !== IW'(5) || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pos: got idx=%0d busy=%b want idx=5 busy=1", scan_idx, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b0 || scan_idx !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got outs=%b idx=%0d want 0", outs(), scan_idx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_scan(8'($urandom), -1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_abort();
        test_start_held();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
